// File: rtl/imem_prog_loader_if.sv
// Byte-stream handshake between a host and the instruction-memory loader.
// The host drives in_valid/in_data; the loader answers with in_ready.
interface imem_prog_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_prog_loader.sv
// Instruction-memory loader: assembles little-endian words from a byte stream and holds the core in reset until the load completes.
// Optional trailing XOR checksum byte is enabled by defining CHECKSUM_EN.
module imem_prog_loader #(
    parameter logic [63:0] START_PC      = 64'h0,
    parameter logic [15:0] MAX_WORDS     = 16'd64,
    parameter int          RELEASE_DELAY = 2
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    input  logic                     load_start,
    imem_prog_loader_if.slave        stream,
    output logic                     imem_we,
    output logic [63:0]              imem_addr,
    output logic [31:0]              imem_wdata,
    output logic                     cpu_reset,
    output logic [63:0]              startpc,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int          HOLD_CYCLES = (RELEASE_DELAY < 1) ? 1 : RELEASE_DELAY;
    localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WR,
        CHK,
        HOLD,
        RUN,
        ERR
    } state_t;

    state_t      state_reg;
    logic        in_ready_reg;
    logic        imem_we_reg;
    logic [63:0] imem_addr_reg;
    logic [31:0] imem_wdata_reg;
    logic        cpu_reset_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        err_reg;
    logic [31:0] word_reg;
    logic [31:0] word_next;
    logic [15:0] n_reg;
    logic [15:0] k_reg;
    logic [15:0] hold_cnt_reg;
    logic [1:0]  byte_cnt_reg;
`ifdef CHECKSUM_EN
    logic [7:0]  csum_reg;
`endif

    logic        accept;
    logic [15:0] hdr_count;
    logic        hdr_bad;
    logic        more_words;
    logic [63:0] word_addr;

    assign accept     = stream.in_valid && in_ready_reg;
    assign hdr_count  = {stream.in_data, n_reg[7:0]};
    assign hdr_bad    = (hdr_count == 16'd0) || (hdr_count > MAX_WORDS);
    assign more_words = ({1'b0, k_reg} + 17'd1) < {1'b0, n_reg};
    assign word_addr  = START_PC + {46'd0, k_reg, 2'b00};

    // The incoming byte lands in the lane selected by byte_cnt; other lanes keep their value.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign word_next[gi*8 +: 8] = (byte_cnt_reg == 2'(gi)) ? stream.in_data
                                                                  : word_reg[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            in_ready_reg   <= 1'b0;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= 64'd0;
            imem_wdata_reg <= 32'd0;
            cpu_reset_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            word_reg       <= 32'd0;
            n_reg          <= 16'd0;
            k_reg          <= 16'd0;
            hold_cnt_reg   <= 16'd0;
            byte_cnt_reg   <= 2'd0;
`ifdef CHECKSUM_EN
            csum_reg       <= 8'd0;
`endif
        end else begin
            // The write strobe is raised only on the transition into WR, so it lasts one cycle.
            imem_we_reg <= 1'b0;

            case (state_reg)
                IDLE, RUN, ERR: begin
                    if (load_start) begin
                        state_reg     <= HDR;
                        in_ready_reg  <= 1'b1;
                        cpu_reset_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        done_reg      <= 1'b0;
                        err_reg       <= 1'b0;
                        word_reg      <= 32'd0;
                        n_reg         <= 16'd0;
                        k_reg         <= 16'd0;
                        hold_cnt_reg  <= 16'd0;
                        byte_cnt_reg  <= 2'd0;
`ifdef CHECKSUM_EN
                        csum_reg      <= 8'd0;
`endif
                    end
                end

                HDR: begin
                    if (accept) begin
`ifdef CHECKSUM_EN
                        csum_reg <= csum_reg ^ stream.in_data;
`endif
                        if (byte_cnt_reg == 2'd0) begin
                            n_reg        <= {8'd0, stream.in_data};
                            byte_cnt_reg <= 2'd1;
                        end else begin
                            n_reg        <= hdr_count;
                            byte_cnt_reg <= 2'd0;
                            if (hdr_bad) begin
                                state_reg    <= ERR;
                                in_ready_reg <= 1'b0;
                                busy_reg     <= 1'b0;
                                err_reg      <= 1'b1;
                            end else begin
                                state_reg    <= DATA;
                            end
                        end
                    end
                end

                DATA: begin
                    if (accept) begin
`ifdef CHECKSUM_EN
                        csum_reg <= csum_reg ^ stream.in_data;
`endif
                        word_reg <= word_next;
                        if (byte_cnt_reg == 2'd3) begin
                            state_reg      <= WR;
                            in_ready_reg   <= 1'b0;
                            byte_cnt_reg   <= 2'd0;
                            imem_we_reg    <= 1'b1;
                            imem_addr_reg  <= word_addr;
                            imem_wdata_reg <= word_next;
                        end else begin
                            byte_cnt_reg   <= byte_cnt_reg + 2'd1;
                        end
                    end
                end

                WR: begin
                    k_reg <= k_reg + 16'd1;
                    if (more_words) begin
                        state_reg    <= DATA;
                        in_ready_reg <= 1'b1;
                    end else begin
`ifdef CHECKSUM_EN
                        state_reg    <= CHK;
                        in_ready_reg <= 1'b1;
`else
                        state_reg    <= HOLD;
                        hold_cnt_reg <= 16'd0;
`endif
                    end
                end

`ifdef CHECKSUM_EN
                CHK: begin
                    if (accept) begin
                        in_ready_reg <= 1'b0;
                        if (stream.in_data == csum_reg) begin
                            state_reg    <= HOLD;
                            hold_cnt_reg <= 16'd0;
                        end else begin
                            state_reg    <= ERR;
                            busy_reg     <= 1'b0;
                            err_reg      <= 1'b1;
                        end
                    end
                end
`endif

                HOLD: begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_reg     <= RUN;
                        cpu_reset_reg <= 1'b0;
                        done_reg      <= 1'b1;
                        busy_reg      <= 1'b0;
                    end else begin
                        hold_cnt_reg  <= hold_cnt_reg + 16'd1;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b0;
                    busy_reg      <= 1'b0;
                    cpu_reset_reg <= 1'b1;
                end
            endcase
        end
    end

    assign stream.in_ready = in_ready_reg;
    assign imem_we         = imem_we_reg;
    assign imem_addr       = imem_addr_reg;
    assign imem_wdata      = imem_wdata_reg;
    assign cpu_reset       = cpu_reset_reg;
    assign startpc         = START_PC;
    assign busy            = busy_reg;
    assign done            = done_reg;
    assign err             = err_reg;

endmodule

// File: tb/tb_imem_prog_loader.sv
// Randomized scoreboard bench for imem_prog_loader: expected writes are queued from a stream-level model
// and popped by a monitor on every imem_we pulse.
module tb_imem_prog_loader;

    localparam logic [63:0] START_PC      = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [15:0] MAX_WORDS     = 16'd64;
    localparam int          RELEASE_DELAY = 2;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_start = 1'b0;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic [63:0] startpc;
    logic        busy;
    logic        done;
    logic        err;

    imem_prog_loader_if stream_if ();

    imem_prog_loader #(
        .START_PC      (START_PC),
        .MAX_WORDS     (MAX_WORDS),
        .RELEASE_DELAY (RELEASE_DELAY)
    ) dut (
        .CLK        (CLK),
        .reset_n    (reset_n),
        .load_start (load_start),
        .stream     (stream_if),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .startpc    (startpc),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] stim_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         writes_seen = 0;
    int         last_we_cyc = 0;
    int         xfer_cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expected write.
    always @(negedge CLK) begin
        if (reset_n && imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=0x%0h data=0x%08h, expected no write", imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", imem_addr, mon_e.addr);
                check("write_data", {32'd0, imem_wdata}, {32'd0, mon_e.data});
            end
            writes_seen++;
            last_we_cyc = cyc;
            $display("write addr=0x%016h data=0x%08h", imem_addr, imem_wdata);
        end
    end

    task automatic append_checksum(input bit corrupt);
`ifdef CHECKSUM_EN
        logic [7:0] x;
        x = 8'd0;
        foreach (stim_q[i]) x ^= stim_q[i];
        if (corrupt) x ^= 8'h5A;
        stim_q.push_back(x);
`else
        if (corrupt) $display("note: this build carries no checksum byte");
`endif
    endtask

    task automatic build_stream(input int n, input bit corrupt);
        logic [15:0] n16;
        n16 = 16'(n);
        stim_q.delete();
        stim_q.push_back(n16[7:0]);
        stim_q.push_back(n16[15:8]);
        for (int i = 0; i < 4 * n; i++) stim_q.push_back(8'($urandom));
        append_checksum(corrupt);
    endtask

    // Stream-level model: header range, little-endian words at START_PC+4*i, optional XOR trailer.
    task automatic model_stream(output bit ok, output int nbytes);
        int         n;
        wr_t        w;
        n  = int'({stim_q[1], stim_q[0]});
        ok = (n != 0) && (n <= int'(MAX_WORDS));
        nbytes = 2;
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                w.addr = START_PC + 64'(4 * i);
                w.data = {stim_q[2+4*i+3], stim_q[2+4*i+2], stim_q[2+4*i+1], stim_q[2+4*i]};
                exp_q.push_back(w);
            end
            nbytes = 2 + 4 * n;
`ifdef CHECKSUM_EN
            begin
                logic [7:0] x;
                x = 8'd0;
                for (int i = 0; i < nbytes; i++) x ^= stim_q[i];
                ok = (stim_q[nbytes] == x);
                nbytes++;
            end
`endif
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
        int idle;
        bit sent;
        idle = (gap == 1) ? 1 : ((gap == 2) ? int'($urandom_range(0, 2)) : 0);
        stream_if.in_valid = 1'b0;
        repeat (idle) begin
            @(posedge CLK);
            #1;
        end
        stream_if.in_valid = 1'b1;
        stream_if.in_data  = b;
        load_start         = pulse;
        sent = 1'b0;
        for (int t = 0; t < 100 && !sent; t++) begin
            @(negedge CLK);
            if (stream_if.in_ready) begin
                sent     = 1'b1;
                xfer_cyc = cyc;
            end
            @(posedge CLK);
            #1;
            load_start = 1'b0;
        end
        stream_if.in_valid = 1'b0;
        if (!sent) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: in_ready stayed 0 for byte 0x%02h, expected acceptance within 100 cycles", b);
        end
    endtask

    task automatic pulse_start();
        @(posedge CLK);
        #1 load_start = 1'b1;
        @(posedge CLK);
        #1 load_start = 1'b0;
    endtask

    task automatic run_load(input string tag, input int gap, input int pulse_idx);
        bit ok;
        int nbytes;
        int exp_writes;
        int fall_cyc;
        int ref_cyc;
        bit finished;
        exp_q.delete();
        model_stream(ok, nbytes);
        exp_writes  = exp_q.size();
        writes_seen = 0;
        pulse_start();
        check({tag, ":start_busy"}, {63'd0, busy}, 64'd1);
        check({tag, ":start_cpu_reset"}, {63'd0, cpu_reset}, 64'd1);
        check({tag, ":start_done"}, {63'd0, done}, 64'd0);
        check({tag, ":start_err"}, {63'd0, err}, 64'd0);
        for (int i = 0; i < nbytes; i++) send_byte(stim_q[i], gap, (i == pulse_idx));
        finished = 1'b0;
        fall_cyc = 0;
        for (int t = 0; t < 500 && !finished; t++) begin
            @(negedge CLK);
            if (!cpu_reset || err) begin
                finished = 1'b1;
                fall_cyc = cyc;
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL %s:completion_timeout: cpu_reset=%0b err=%0b, expected release or err within 500 cycles",
                     tag, cpu_reset, err);
        end
        check({tag, ":done"}, {63'd0, done}, {63'd0, ok});
        check({tag, ":err"}, {63'd0, err}, {63'd0, !ok});
        check({tag, ":cpu_reset"}, {63'd0, cpu_reset}, {63'd0, !ok});
        check({tag, ":busy"}, {63'd0, busy}, 64'd0);
        check({tag, ":in_ready"}, {63'd0, stream_if.in_ready}, 64'd0);
        check({tag, ":write_count"}, 64'(writes_seen), 64'(exp_writes));
        check({tag, ":pending_writes"}, 64'(exp_q.size()), 64'd0);
        if (ok && finished) begin
`ifdef CHECKSUM_EN
            ref_cyc = xfer_cyc;
`else
            ref_cyc = last_we_cyc;
`endif
            check({tag, ":release_delay"}, 64'(fall_cyc - ref_cyc), 64'(RELEASE_DELAY + 1));
        end
        $display("load %s: bytes=%0d expect_ok=%0b writes=%0d", tag, nbytes, ok, writes_seen);
        exp_q.delete();
    endtask

    task automatic spec_stream();
        stim_q = '{8'h02, 8'h00, 8'h29, 8'h00, 8'h40, 8'hF9, 8'h0A, 8'h01, 8'h0B, 8'h8B};
        append_checksum(1'b0);
    endtask

    initial begin
        stream_if.in_valid = 1'b0;
        stream_if.in_data  = 8'd0;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst:cpu_reset", {63'd0, cpu_reset}, 64'd1);
        check("rst:imem_we", {63'd0, imem_we}, 64'd0);
        check("rst:in_ready", {63'd0, stream_if.in_ready}, 64'd0);
        check("rst:done", {63'd0, done}, 64'd0);
        check("rst:err", {63'd0, err}, 64'd0);
        check("rst:busy", {63'd0, busy}, 64'd0);
        check("rst:imem_addr", imem_addr, 64'd0);
        check("rst:imem_wdata", {32'd0, imem_wdata}, 64'd0);
        check("rst:startpc", startpc, START_PC);
        reset_n = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("idle:cpu_reset", {63'd0, cpu_reset}, 64'd1);

        // Reference two-word load, continuous and with alternate-cycle gaps
        spec_stream();
        run_load("spec_nogap", 0, -1);
        spec_stream();
        run_load("spec_altgap", 1, -1);

        // Bad word counts
        stim_q = '{8'h00, 8'h00};
        run_load("bad_zero", 0, -1);
        stim_q = '{8'h41, 8'h00};
        run_load("bad_65", 0, -1);

        // Boundary counts
        build_stream(1, 1'b0);
        run_load("n_one", 2, -1);
        build_stream(int'(MAX_WORDS), 1'b0);
        run_load("n_max", 0, -1);

        // load_start while in RUN restarts; load_start mid-DATA is ignored
        build_stream(3, 1'b0);
        run_load("pulse_mid_data", 0, 4);
        build_stream(2, 1'b0);
        run_load("pulse_mid_data_gap", 1, 7);

        // Reset after two data bytes aborts; a fresh load starts at START_PC
        build_stream(3, 1'b0);
        exp_q.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(stim_q[i], 0, 1'b0);
        reset_n = 1'b0;
        #1;
        check("abort:in_ready", {63'd0, stream_if.in_ready}, 64'd0);
        check("abort:busy", {63'd0, busy}, 64'd0);
        check("abort:cpu_reset", {63'd0, cpu_reset}, 64'd1);
        check("abort:imem_we", {63'd0, imem_we}, 64'd0);
        repeat (2) @(posedge CLK);
        #1 reset_n = 1'b1;
        build_stream(2, 1'b0);
        run_load("fresh_after_abort", 0, -1);

`ifdef CHECKSUM_EN
        build_stream(3, 1'b1);
        run_load("bad_checksum", 0, -1);
        spec_stream();
        stim_q[stim_q.size()-1] ^= 8'h01;
        run_load("spec_bad_checksum", 1, -1);
`endif

        // Randomized loads
        for (int r = 0; r < 6; r++) begin
            build_stream(int'($urandom_range(1, 8)), 1'b0);
            run_load($sformatf("rand%0d", r), int'($urandom_range(0, 2)),
                     ($urandom_range(0, 1) == 1) ? 6 : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
